// File: rtl/bcd_up_scan_if.sv
// Bus bundle for the two-digit BCD up-counter: count/clear controls in,
// BCD digits, wrap carry and multiplexed seven-segment drive out.
interface bcd_up_scan_if;
    logic       sw;
    logic       sw1;
    logic [3:0] ones;
    logic [3:0] tens;
    logic       carry;
    logic [7:0] out;
    logic [3:0] am;

    modport master (
        output sw, sw1,
        input  ones, tens, carry, out, am
    );

    modport slave (
        input  sw, sw1,
        output ones, tens, carry, out, am
    );
endinterface

// File: rtl/bcd_up_scan.sv
// Prescaled 00-99 BCD up-counter with wrap carry and a two-digit multiplexed
// active-low seven-segment driver. Optional macro LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module bcd_up_scan #(
    parameter int TICK_BITS = 25,
    parameter int SCAN_BITS = 17
) (
    input  logic          clk,
    input  logic          reset,
    bcd_up_scan_if.slave  bus
);

    logic [TICK_BITS-1:0] presc_r;
    logic [SCAN_BITS-1:0] scan_r;
    logic [3:0]           ones_r;
    logic [3:0]           tens_r;
    logic                 carry_r;
    logic [7:0]           out_r;
    logic [3:0]           am_r;

    logic                 tick_s;
    logic                 sel_s;
    logic [3:0]           ones_nxt_s;
    logic [3:0]           tens_nxt_s;
    logic                 carry_nxt_s;
    logic [3:0]           digit_s;
    logic [7:0]           seg_s;
    logic [3:0]           am_nxt_s;

    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'b0000_0011;
            4'd1:    s = 8'b1001_1111;
            4'd2:    s = 8'b0010_0101;
            4'd3:    s = 8'b0000_1101;
            4'd4:    s = 8'b1001_1001;
            4'd5:    s = 8'b0100_1001;
            4'd6:    s = 8'b1100_0001;
            4'd7:    s = 8'b0001_1011;
            4'd8:    s = 8'b0000_0001;
            4'd9:    s = 8'b0000_1001;
            default: s = 8'b1111_1111;
        endcase
        return s;
    endfunction

    assign tick_s = &presc_r;
    assign sel_s  = scan_r[SCAN_BITS-1];

    // Next digit values: clear beats tick; an out-of-range digit folds to 0 like a 9.
    always_comb begin
        ones_nxt_s  = ones_r;
        tens_nxt_s  = tens_r;
        carry_nxt_s = 1'b0;
        if (bus.sw1) begin
            ones_nxt_s  = 4'd0;
            tens_nxt_s  = 4'd0;
        end else if (tick_s && bus.sw) begin
            if (ones_r >= 4'd9) begin
                ones_nxt_s = 4'd0;
                if (tens_r >= 4'd9) begin
                    tens_nxt_s  = 4'd0;
                    carry_nxt_s = 1'b1;
                end else begin
                    tens_nxt_s  = tens_r + 4'd1;
                end
            end else begin
                ones_nxt_s = ones_r + 4'd1;
            end
        end else begin
            ones_nxt_s = ones_r;
        end
    end

    // Display selection and segment code for the digit currently being scanned.
    always_comb begin
        digit_s  = ones_r;
        am_nxt_s = 4'b1110;
        if (sel_s) begin
            digit_s  = tens_r;
            am_nxt_s = 4'b1101;
        end else begin
            digit_s  = ones_r;
            am_nxt_s = 4'b1110;
        end
        seg_s = seg_decode(digit_s);
`ifdef LEADING_ZERO_BLANK_EN
        if (sel_s && (tens_r == 4'd0)) begin
            seg_s = 8'b1111_1111;
        end else begin
            seg_s = seg_decode(digit_s);
        end
`endif
    end

    // State and registered display outputs; reset is synchronous active-low.
    always_ff @(posedge clk) begin
        if (!reset) begin
            presc_r <= '0;
            scan_r  <= '0;
            ones_r  <= 4'd0;
            tens_r  <= 4'd0;
            carry_r <= 1'b0;
            out_r   <= 8'b1111_1111;
            am_r    <= 4'b1111;
        end else begin
            presc_r <= presc_r + TICK_BITS'(1);
            scan_r  <= scan_r + SCAN_BITS'(1);
            ones_r  <= ones_nxt_s;
            tens_r  <= tens_nxt_s;
            carry_r <= carry_nxt_s;
            out_r   <= seg_s;
            am_r    <= am_nxt_s;
        end
    end

    assign bus.ones  = ones_r;
    assign bus.tens  = tens_r;
    assign bus.carry = carry_r;
    assign bus.out   = out_r;
    assign bus.am    = am_r;

endmodule
